// File: rtl/dual_issue_scheduler_if.sv
// Fetch-buffer / execute-side handshake bundle for dual_issue_scheduler.
// slave = scheduler side, master = the surrounding pipeline (buffer + execute).
interface dual_issue_scheduler_if;
  logic [31:0] instruction0;
  logic [31:0] instruction1;
  logic        nothing_filled;
  logic        ex_stall;
  logic        flush;
  logic        freeze1;
  logic        freeze2;
  logic        dependency_on_ins2;
  logic        issue0_valid;
  logic [31:0] issue0_instr;
  logic        issue1_valid;
  logic [31:0] issue1_instr;

  modport slave (
    input  instruction0, instruction1, nothing_filled, ex_stall, flush,
    output freeze1, freeze2, dependency_on_ins2,
           issue0_valid, issue0_instr, issue1_valid, issue1_instr
  );

  modport master (
    output instruction0, instruction1, nothing_filled, ex_stall, flush,
    input  freeze1, freeze2, dependency_on_ins2,
           issue0_valid, issue0_instr, issue1_valid, issue1_instr
  );
endinterface

// File: rtl/dual_issue_scheduler.sv
// RV32I dual-issue stage: hazard checks, per-register latency scoreboard, issue registers.
// Optional performance counters are enabled with `define SCHED_PERF_CNT_EN.
module dual_issue_scheduler #(
  parameter int LOAD_LAT = 2,
  parameter int ALU_LAT  = 0
) (
  input  logic clk,
  input  logic rst,
  dual_issue_scheduler_if.slave bus
`ifdef SCHED_PERF_CNT_EN
  ,
  output logic [31:0] perf_issued,
  output logic [31:0] perf_dual,
  output logic [31:0] perf_stall
`endif
);

  localparam int MAX_LAT = (LOAD_LAT > ALU_LAT) ? LOAD_LAT : ALU_LAT;
  localparam int CW      = (MAX_LAT < 1) ? 1 : $clog2(MAX_LAT + 1);
  localparam logic [CW-1:0] LOAD_SET = CW'(LOAD_LAT);
  localparam logic [CW-1:0] ALU_SET  = CW'(ALU_LAT);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic       rd_rs1;
    logic       rd_rs2;
    logic       wr_rd;
    logic       is_load;
    logic       is_mem;
    logic       is_ctrl;
    logic       is_sys;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] ins);
    dec_t       d;
    logic [6:0] op;
    op        = ins[6:0];
    d.rs1     = ins[19:15];
    d.rs2     = ins[24:20];
    d.rd      = ins[11:7];
    d.rd_rs2  = (op == OP_R) || (op == OP_STORE) || (op == OP_BRANCH);
    d.rd_rs1  = d.rd_rs2 || (op == OP_IMM) || (op == OP_LOAD) ||
                (op == OP_JALR) || (op == OP_SYSTEM);
    d.wr_rd   = (op == OP_R) || (op == OP_IMM) || (op == OP_LOAD) || (op == OP_JAL) ||
                (op == OP_JALR) || (op == OP_LUI) || (op == OP_AUIPC) || (op == OP_SYSTEM);
    d.is_load = (op == OP_LOAD);
    d.is_mem  = (op == OP_LOAD) || (op == OP_STORE);
    d.is_ctrl = (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR) || (op == OP_SYSTEM);
    d.is_sys  = (op == OP_SYSTEM);
    return d;
  endfunction

  logic [CW-1:0] cnt [32];
  logic [31:0]   busy;
  logic [31:0]   set0, set1;
  dec_t          d0, d1;
  logic          haz0, haz1, sb1, other1;
  logic          go0, go1;

  assign d0 = decode(bus.instruction0);
  assign d1 = decode(bus.instruction1);

  always_comb begin
    for (int i = 0; i < 32; i++) busy[i] = (i != 0) && (cnt[i] != '0);
  end

  // Hazard terms; x0 is never busy because its counter is never loaded.
  always_comb begin
    haz0   = (d0.rd_rs1 && busy[d0.rs1]) || (d0.rd_rs2 && busy[d0.rs2]);
    sb1    = (d1.rd_rs1 && busy[d1.rs1]) || (d1.rd_rs2 && busy[d1.rs2]);
    other1 = (bus.instruction1 == 32'h0) ||
             (d0.wr_rd && (d0.rd != 5'd0) &&
              ((d1.rd_rs1 && d1.rs1 == d0.rd) || (d1.rd_rs2 && d1.rs2 == d0.rd))) ||
             (d0.wr_rd && d1.wr_rd && (d0.rd != 5'd0) && (d0.rd == d1.rd)) ||
             (d0.is_mem && d1.is_mem) ||
             d0.is_ctrl || d1.is_sys;
    haz1   = other1 || sb1;
  end

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    bus.freeze1            = 1'b0;
    bus.freeze2            = 1'b0;
    bus.dependency_on_ins2 = 1'b0;
    go0                    = 1'b0;
    go1                    = 1'b0;
    if (rst) begin
      go0 = 1'b0;
    end else if (bus.flush || bus.ex_stall) begin
      bus.freeze1 = 1'b1;
    end else if (bus.nothing_filled || bus.instruction0 == 32'h0) begin
      go0 = 1'b0;
    end else if (haz0) begin
      bus.freeze1 = 1'b1;
    end else if (haz1) begin
      bus.dependency_on_ins2 = 1'b1;
      bus.freeze2            = sb1 && !other1;
      go0                    = 1'b1;
    end else begin
      go0 = 1'b1;
      go1 = 1'b1;
    end
  end

  always_comb begin
    set0 = '0;
    set1 = '0;
    if (go0 && d0.wr_rd && d0.rd != 5'd0) set0[d0.rd] = 1'b1;
    if (go1 && d1.wr_rd && d1.rd != 5'd0) set1[d1.rd] = 1'b1;
  end

  // NOTE: the scoreboard is 32 small counters, not a RAM, so it is reset like any
  // other state; an asynchronous reset must drop every in-flight entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) cnt[i] <= '0;
    end else if (!bus.ex_stall) begin
      for (int i = 0; i < 32; i++) begin
        if (set1[i])              cnt[i] <= d1.is_load ? LOAD_SET : ALU_SET;
        else if (set0[i])         cnt[i] <= d0.is_load ? LOAD_SET : ALU_SET;
        else if (cnt[i] != '0)    cnt[i] <= cnt[i] - CW'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update
  // from the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || bus.flush) begin
      bus.issue0_valid <= 1'b0;
      bus.issue0_instr <= 32'h0;
      bus.issue1_valid <= 1'b0;
      bus.issue1_instr <= 32'h0;
    end else if (!bus.ex_stall) begin
      bus.issue0_valid <= go0;
      bus.issue0_instr <= go0 ? bus.instruction0 : 32'h0;
      bus.issue1_valid <= go1;
      bus.issue1_instr <= go1 ? bus.instruction1 : 32'h0;
    end
  end

`ifdef SCHED_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_issued <= 32'h0;
      perf_dual   <= 32'h0;
      perf_stall  <= 32'h0;
    end else begin
      perf_issued <= perf_issued + 32'(go0) + 32'(go1);
      perf_dual   <= perf_dual + 32'(go1);
      perf_stall  <= perf_stall + 32'(bus.freeze1);
    end
  end
`endif

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Directed bench for dual_issue_scheduler (default build, LOAD_LAT=2, ALU_LAT=0).
module tb_dual_issue_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  localparam logic [31:0] ADDI_X1  = 32'h00500093;
  localparam logic [31:0] ADDI_X2  = 32'h00700113;
  localparam logic [31:0] ADD_X2X1 = 32'h00108133;
  localparam logic [31:0] LW_X3    = 32'h00002183;
  localparam logic [31:0] LW_X4    = 32'h00402203;
  localparam logic [31:0] ADDI_X4  = 32'h00100213;
  localparam logic [31:0] ADD_X5X3 = 32'h003182b3;

  dual_issue_scheduler_if bus ();

  dual_issue_scheduler #(.LOAD_LAT(2), .ALU_LAT(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i0, input logic [31:0] i1);
    bus.instruction0   = i0;
    bus.instruction1   = i1;
    bus.nothing_filled = 1'b0;
    #1;
  endtask

  task automatic flags(input string tag, input logic f1, input logic f2, input logic dep);
    check({tag, ".freeze1"}, 32'(bus.freeze1), 32'(f1));
    check({tag, ".freeze2"}, 32'(bus.freeze2), 32'(f2));
    check({tag, ".dep"}, 32'(bus.dependency_on_ins2), 32'(dep));
  endtask

  task automatic issued(input string tag, input logic v0, input logic [31:0] i0,
                        input logic v1, input logic [31:0] i1);
    check({tag, ".v0"}, 32'(bus.issue0_valid), 32'(v0));
    check({tag, ".i0"}, bus.issue0_instr, i0);
    check({tag, ".v1"}, 32'(bus.issue1_valid), 32'(v1));
    check({tag, ".i1"}, bus.issue1_instr, i1);
  endtask

  task automatic idle(input int n);
    bus.nothing_filled = 1'b1;
    bus.instruction0   = 32'h0;
    bus.instruction1   = 32'h0;
    repeat (n) tick();
  endtask

  initial begin
    bus.instruction0   = 32'h0;
    bus.instruction1   = 32'h0;
    bus.nothing_filled = 1'b1;
    bus.ex_stall       = 1'b0;
    bus.flush          = 1'b0;

    // Reset state with a valid-looking pair present.
    #2;
    drive(ADDI_X1, ADDI_X2);
    flags("reset", 1'b0, 1'b0, 1'b0);
    tick();
    issued("reset", 1'b0, 32'h0, 1'b0, 32'h0);
    rst = 1'b0;
    idle(1);

    // T1: independent pair dual-issues.
    drive(ADDI_X1, ADDI_X2);
    flags("t1", 1'b0, 1'b0, 1'b0);
    tick();
    issued("t1", 1'b1, ADDI_X1, 1'b1, ADDI_X2);

    // T5: ex_stall holds the issue registers for 3 edges.
    bus.ex_stall = 1'b1;
    drive(ADDI_X1, ADD_X2X1);
    flags("t5.stall", 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      issued($sformatf("t5.hold%0d", k), 1'b1, ADDI_X1, 1'b1, ADDI_X2);
    end
    bus.flush = 1'b1;
    #1;
    flags("t5.flush", 1'b1, 1'b0, 1'b0);
    tick();
    issued("t5.flush", 1'b0, 32'h0, 1'b0, 32'h0);
    bus.flush    = 1'b0;
    bus.ex_stall = 1'b0;

    // T2: RAW inside the pair, slot0 only.
    drive(ADDI_X1, ADD_X2X1);
    flags("t2", 1'b0, 1'b0, 1'b1);
    tick();
    issued("t2", 1'b1, ADDI_X1, 1'b0, 32'h0);

    // nothing_filled: no issue, no flags.
    bus.nothing_filled = 1'b1;
    #1;
    flags("empty", 1'b0, 1'b0, 1'b0);
    tick();
    issued("empty", 1'b0, 32'h0, 1'b0, 32'h0);

    // T4: two memory ops, then the second issues alone.
    drive(LW_X3, LW_X4);
    flags("t4.a", 1'b0, 1'b0, 1'b1);
    tick();
    issued("t4.a", 1'b1, LW_X3, 1'b0, 32'h0);
    drive(LW_X4, 32'h0);
    flags("t4.b", 1'b0, 1'b0, 1'b1);
    tick();
    issued("t4.b", 1'b1, LW_X4, 1'b0, 32'h0);

    // freeze2: slot1 blocked only by x4 still in flight (set one edge ago).
    drive(ADDI_X1, 32'h00420333);
    flags("freeze2", 1'b0, 1'b1, 1'b1);
    tick();
    issued("freeze2", 1'b1, ADDI_X1, 1'b0, 32'h0);
    idle(3);

    // T3: load-use stalls two cycles after the load issues.
    drive(LW_X3, ADDI_X4);
    flags("t3.t", 1'b0, 1'b0, 1'b0);
    tick();
    issued("t3.t", 1'b1, LW_X3, 1'b1, ADDI_X4);
    drive(ADD_X5X3, 32'h0);
    flags("t3.t1", 1'b1, 1'b0, 1'b0);
    tick();
    issued("t3.t1", 1'b0, 32'h0, 1'b0, 32'h0);
    flags("t3.t2", 1'b1, 1'b0, 1'b0);
    tick();
    flags("t3.t3", 1'b0, 1'b0, 1'b1);
    tick();
    issued("t3.t3", 1'b1, ADD_X5X3, 1'b0, 32'h0);
    idle(3);

    // Scoreboard frozen under ex_stall: the two load-use stalls remain after release.
    drive(LW_X3, ADDI_X4);
    tick();
    bus.ex_stall = 1'b1;
    drive(ADD_X5X3, 32'h0);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("sbhold%0d.freeze1", k), 32'(bus.freeze1), 32'd1);
      tick();
    end
    bus.ex_stall = 1'b0;
    #1;
    flags("sbhold.r1", 1'b1, 1'b0, 1'b0);
    tick();
    flags("sbhold.r2", 1'b1, 1'b0, 1'b0);
    tick();
    flags("sbhold.r3", 1'b0, 1'b0, 1'b1);
    tick();
    issued("sbhold", 1'b1, ADD_X5X3, 1'b0, 32'h0);
    idle(3);

    // T6: asynchronous reset between edges clears state and the pending load.
    drive(LW_X3, ADDI_X4);
    tick();
    drive(ADD_X5X3, 32'h0);
    flags("t6.pre", 1'b1, 1'b0, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    flags("t6.rst", 1'b0, 1'b0, 1'b0);
    issued("t6.rst", 1'b0, 32'h0, 1'b0, 32'h0);
    rst = 1'b0;
    #1;
    flags("t6.after", 1'b0, 1'b0, 1'b1);
    tick();
    issued("t6.after", 1'b1, ADD_X5X3, 1'b0, 32'h0);

    idle(1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
